coram_read_dma: RTL

//  Read-DMA engine feeding the user-bus side of the AXI master interface.

---
 rtl/coram_read_dma_pkg.sv | 22 ++
 rtl/coram_dma_burst_calc.sv | 26 ++
 rtl/coram_read_dma.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/coram_read_dma_pkg.sv
// rtl/coram_read_dma_pkg.sv - shared FSM states, 4KB boundary constant and log2 helper for the read DMA
package coram_read_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned BOUNDARY_BYTES = 4096;

  function automatic int unsigned clog2_fn(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coram_dma_burst_calc.sv
// rtl/coram_dma_burst_calc.sv - combinational burst sizer: min(remaining, max burst, beats to next 4KB boundary)
module coram_dma_burst_calc
  import coram_read_dma_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [SIZE_WIDTH-1:0] remaining,
  input  logic [11:0]           addr_offset,
  output logic [8:0]            len,
  output logic [7:0]            arlen
);

  localparam int BEAT_SHIFT = clog2_fn(DATA_WIDTH / 8);

  logic [12:0] to_boundary;
  logic [12:0] limit;

  // addr_offset is beat aligned, so at least one beat always fits before the boundary
  assign to_boundary = (13'(BOUNDARY_BYTES) - {1'b0, addr_offset}) >> BEAT_SHIFT;
  assign limit       = (to_boundary < 13'(MAX_BURST_LEN)) ? to_boundary : 13'(MAX_BURST_LEN);
  assign len         = (remaining < SIZE_WIDTH'(limit)) ? 9'(remaining) : 9'(limit);
  assign arlen       = 8'(len - 9'd1);

endmodule

// File: rtl/coram_read_dma.sv
// rtl/coram_read_dma.sv - read DMA: splits one command into INCR bursts and streams beats into local RAM
// Optional CORAM_DMA_RLAST_CHECK_EN counts beats per burst and adds a sticky protocol_error output.
module coram_read_dma
  import coram_read_dma_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int SIZE_WIDTH     = 32,
  parameter int MAX_BURST_LEN  = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
`ifdef CORAM_DMA_RLAST_CHECK_EN
  output logic                      protocol_error,
`endif
  input  logic                      cmd_valid,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [SIZE_WIDTH-1:0]     cmd_size,
  input  logic [RAM_ADDR_WIDTH-1:0] cmd_ram_addr,
  output logic                      cmd_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      arvalid,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  input  logic                      arready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata
);

  localparam int BEAT_SHIFT = clog2_fn(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'((1 << BEAT_SHIFT) - 1);

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]     remaining_q, remaining_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_ptr_q, ram_ptr_d;
  logic [8:0]                len_q, len_d;
  logic                      arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic                      done_q, done_d;
  logic                      ram_we_q, ram_we_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
  logic [8:0]                calc_len;
  logic [7:0]                calc_arlen;
  logic                      burst_end;
`ifdef CORAM_DMA_RLAST_CHECK_EN
  logic [8:0]                beat_cnt_q, beat_cnt_d;
  logic                      perr_q, perr_d;
  logic                      beat_is_len;
`endif

  coram_dma_burst_calc #(
    .DATA_WIDTH    (DATA_WIDTH),
    .SIZE_WIDTH    (SIZE_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_burst_calc (
    .remaining   (remaining_q),
    .addr_offset (addr_q[11:0]),
    .len         (calc_len),
    .arlen       (calc_arlen)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    ram_ptr_d   = ram_ptr_q;
    len_d       = len_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    done_d      = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    burst_end   = 1'b0;
`ifdef CORAM_DMA_RLAST_CHECK_EN
    beat_cnt_d  = beat_cnt_q;
    perr_d      = perr_q;
    beat_is_len = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ~BEAT_MASK;
          remaining_d = cmd_size;
          ram_ptr_d   = cmd_ram_addr;
          if (cmd_size == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // First REQ cycle loads the AR registers; they then stay frozen until arready
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = calc_arlen;
          len_d     = calc_len;
        end else if (arready) begin
          arvalid_d   = 1'b0;
          remaining_d = remaining_q - SIZE_WIDTH'(len_q);
          addr_d      = addr_q + (ADDR_WIDTH'(len_q) << BEAT_SHIFT);
          state_d     = ST_DATA;
`ifdef CORAM_DMA_RLAST_CHECK_EN
          beat_cnt_d  = '0;
`endif
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = ram_ptr_q;
          ram_wdata_d = rdata;
          ram_ptr_d   = ram_ptr_q + RAM_ADDR_WIDTH'(1);
`ifdef CORAM_DMA_RLAST_CHECK_EN
          beat_cnt_d  = beat_cnt_q + 9'd1;
          beat_is_len = (beat_cnt_d == len_q);
          burst_end   = beat_is_len;
          if (rlast != beat_is_len) perr_d = 1'b1;
`else
          burst_end   = rlast;
`endif
          if (burst_end) begin
            if (remaining_q == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      ram_ptr_q   <= '0;
      len_q       <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      done_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef CORAM_DMA_RLAST_CHECK_EN
      beat_cnt_q  <= '0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      ram_ptr_q   <= ram_ptr_d;
      len_q       <= len_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      done_q      <= done_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef CORAM_DMA_RLAST_CHECK_EN
      beat_cnt_q  <= beat_cnt_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rready    = (state_q == ST_DATA);
  assign done      = done_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
`ifdef CORAM_DMA_RLAST_CHECK_EN
  assign protocol_error = perr_q;
`endif

endmodule
